// File: rtl/rx_depuncture.sv
// rx_depuncture: re-inserts erasures so the Viterbi decoder sees rate-1/2 (A,B) soft pairs
module rx_depuncture #(
    parameter int SOFT_W = 4
) (
    input  logic              clk_Modulation,
    input  logic              reset,
    input  logic [1:0]        rx_ConvCodeRate,
    input  logic              rx_deint_valid,
    input  logic [SOFT_W-1:0] rx_deint_soft,
    input  logic              rx_deint_last,
    output logic              rx_depunc_valid,
    output logic [SOFT_W-1:0] rx_depunc_soft_a,
    output logic [SOFT_W-1:0] rx_depunc_soft_b,
    output logic [1:0]        rx_depunc_erase,
    output logic              rx_depunc_last,
    output logic              rx_depunc_pair_cnt_valid,
    output logic [15:0]       rx_depunc_pair_cnt
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t            state, state_nxt;
    logic [1:0]        rate_q, rate_cur, ph, ph_nxt, ph_end, era_nxt;
    logic [SOFT_W-1:0] hold_a, a_nxt, b_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic              emit;
    always_comb begin
        rate_cur  = (state == IDLE) ? rx_ConvCodeRate : rate_q;
        ph_end    = (rate_cur == 2'b01) ? 2'd2 : (rate_cur == 2'b10) ? 2'd3 : 2'd1;
        emit      = rx_deint_valid && (ph != 2'd0 || rx_deint_last);
        a_nxt     = (ph == 2'd1) ? hold_a : (ph == 2'd3) ? '0 : rx_deint_soft;
        b_nxt     = (ph == 2'd1 || ph == 2'd3) ? rx_deint_soft : '0;
        era_nxt   = (ph == 2'd1) ? 2'b00 : (ph == 2'd3) ? 2'b10 : 2'b01;
        ph_nxt    = !rx_deint_valid ? ph : (rx_deint_last || ph == ph_end) ? 2'd0 : ph + 2'd1;
        state_nxt = !rx_deint_valid ? state : rx_deint_last ? IDLE : RUN;
        cnt_nxt   = rx_depunc_last ? {15'd0, emit} : (emit && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    end
    always_ff @(posedge clk_Modulation) begin
        if (reset) begin
            state                    <= IDLE;
            rate_q                   <= '0;
            ph                       <= '0;
            hold_a                   <= '0;
            cnt                      <= '0;
            rx_depunc_valid          <= 1'b0;
            rx_depunc_soft_a         <= '0;
            rx_depunc_soft_b         <= '0;
            rx_depunc_erase          <= '0;
            rx_depunc_last           <= 1'b0;
            rx_depunc_pair_cnt_valid <= 1'b0;
            rx_depunc_pair_cnt       <= '0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && rx_deint_valid)
                rate_q <= rx_ConvCodeRate;
            if (rx_deint_valid && ph == 2'd0)
                hold_a <= rx_deint_soft;
            rx_depunc_valid          <= emit;
            rx_depunc_soft_a         <= emit ? a_nxt : '0;
            rx_depunc_soft_b         <= emit ? b_nxt : '0;
            rx_depunc_erase          <= emit ? era_nxt : 2'b00;
            rx_depunc_last           <= emit && rx_deint_last;
            rx_depunc_pair_cnt_valid <= rx_depunc_last;
            if (rx_depunc_last)
                rx_depunc_pair_cnt <= cnt;
        end
    end
endmodule

// File: tb/tb_rx_depuncture.sv
// tb_rx_depuncture: directed frames against hand-computed pair/erase/count tables
module tb_rx_depuncture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rate = 2'b00;
    logic        in_valid = 1'b0;
    logic [3:0]  in_soft = '0;
    logic        in_last = 1'b0;
    logic        out_valid, out_last, cnt_valid;
    logic [3:0]  out_a, out_b;
    logic [1:0]  out_erase;
    logic [15:0] pair_cnt;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          idle_bad = 0;
    typedef struct {logic [15:0] v; int c;} ev_t;
    ev_t         pq[$];
    ev_t         cq[$];
    logic [15:0] ex_v[$];
    int          ex_i[$];
    int          in_cyc[$];

    rx_depuncture #(.SOFT_W(4)) dut (
        .clk_Modulation(clk),
        .reset(reset),
        .rx_ConvCodeRate(rate),
        .rx_deint_valid(in_valid),
        .rx_deint_soft(in_soft),
        .rx_deint_last(in_last),
        .rx_depunc_valid(out_valid),
        .rx_depunc_soft_a(out_a),
        .rx_depunc_soft_b(out_b),
        .rx_depunc_erase(out_erase),
        .rx_depunc_last(out_last),
        .rx_depunc_pair_cnt_valid(cnt_valid),
        .rx_depunc_pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (out_valid) begin
            e.v = {5'd0, out_a, out_b, out_erase, out_last};
            e.c = cyc;
            pq.push_back(e);
        end else if ({out_a, out_b, out_erase, out_last} != 11'd0) begin
            idle_bad++;
        end
        if (cnt_valid) begin
            e.v = pair_cnt;
            e.c = cyc;
            cq.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic [3:0] s, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_soft  = s;
        in_last  = l;
        in_cyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_soft  = '0;
            in_last  = 1'b0;
        end
    endtask

    task automatic exp_pair(input logic [3:0] a, input logic [3:0] b, input logic [1:0] e,
                            input logic l, input int i);
        ex_v.push_back({5'd0, a, b, e, l});
        ex_i.push_back(i);
    endtask

    task automatic finish_frame(input string name, input logic has_cnt, input logic [15:0] ecnt);
        int last_c;
        idle(4);
        check({name, ".npairs"}, pq.size(), ex_v.size());
        for (int k = 0; k < ex_v.size(); k++) begin
            if (k < pq.size()) begin
                check($sformatf("%s.pair%0d", name, k), pq[k].v, ex_v[k]);
                check($sformatf("%s.cyc%0d", name, k), pq[k].c, in_cyc[ex_i[k]] + 1);
            end
        end
        last_c = in_cyc[ex_i[ex_i.size()-1]] + 1;
        check({name, ".npulse"}, cq.size(), has_cnt ? 1 : 0);
        if (has_cnt && cq.size() > 0) begin
            check({name, ".cnt"}, cq[0].v, ecnt);
            check({name, ".cntcyc"}, cq[0].c, last_c + 1);
            check({name, ".held"}, pair_cnt, ecnt);
        end
        check({name, ".idlezero"}, idle_bad, 0);
        pq.delete(); cq.delete(); ex_v.delete(); ex_i.delete(); in_cyc.delete();
        idle_bad = 0;
    endtask

    task automatic exp_t1;
        exp_pair(4'd1, 4'd2, 2'b00, 1'b0, 1);
        exp_pair(4'd3, 4'd0, 2'b01, 1'b0, 2);
        exp_pair(4'd0, 4'd4, 2'b10, 1'b0, 3);
        exp_pair(4'd5, 4'd6, 2'b00, 1'b0, 5);
        exp_pair(4'd7, 4'd0, 2'b01, 1'b0, 6);
        exp_pair(4'd0, 4'd8, 2'b10, 1'b1, 7);
    endtask

    initial begin
        idle(2);
        check("reset.outs", {out_valid, out_a, out_b, out_erase, out_last, cnt_valid}, 13'd0);
        check("reset.cnt", pair_cnt, 16'd0);
        reset = 1'b0;
        idle(2);
        // T1: rate 3/4 back-to-back
        rate = 2'b10;
        for (int i = 1; i <= 8; i++) drive(4'(i), i == 8);
        exp_t1();
        finish_frame("T1", 1'b1, 16'd6);
        // T2: rate 1/2
        rate = 2'b00;
        for (int i = 1; i <= 6; i++) drive(4'(i), i == 6);
        exp_pair(4'd1, 4'd2, 2'b00, 1'b0, 1);
        exp_pair(4'd3, 4'd4, 2'b00, 1'b0, 3);
        exp_pair(4'd5, 4'd6, 2'b00, 1'b1, 5);
        finish_frame("T2", 1'b1, 16'd3);
        // T3: rate 2/3 with ph0 flush
        rate = 2'b01;
        for (int i = 10; i <= 13; i++) drive(4'(i), i == 13);
        exp_pair(4'hA, 4'hB, 2'b00, 1'b0, 1);
        exp_pair(4'hC, 4'h0, 2'b01, 1'b0, 2);
        exp_pair(4'hD, 4'h0, 2'b01, 1'b1, 3);
        finish_frame("T3", 1'b1, 16'd3);
        // T4: rate 3/4 with gaps
        rate = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) idle(1);
            drive(4'(i), i == 8);
        end
        exp_t1();
        finish_frame("T4", 1'b1, 16'd6);
        // T5: rate change mid-frame ignored, next frame picks it up
        rate = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            drive(4'(i), i == 8);
            if (i == 2) rate = 2'b00;
        end
        exp_t1();
        finish_frame("T5a", 1'b1, 16'd6);
        for (int i = 1; i <= 4; i++) drive(4'(i), i == 4);
        exp_pair(4'd1, 4'd2, 2'b00, 1'b0, 1);
        exp_pair(4'd3, 4'd4, 2'b00, 1'b1, 3);
        finish_frame("T5b", 1'b1, 16'd2);
        // T6: reset mid-frame
        rate = 2'b10;
        for (int i = 1; i <= 3; i++) drive(4'(i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_soft  = '0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("T6.rstouts", {out_valid, out_a, out_b, out_erase, out_last, cnt_valid}, 13'd0);
        exp_pair(4'd1, 4'd2, 2'b00, 1'b0, 1);
        exp_pair(4'd3, 4'd0, 2'b01, 1'b0, 2);
        finish_frame("T6a", 1'b0, 16'd0);
        rate = 2'b00;
        drive(4'd5, 1'b0);
        drive(4'hD, 1'b1);
        exp_pair(4'd5, 4'hD, 2'b00, 1'b1, 1);
        finish_frame("T6b", 1'b1, 16'd1);
        // T7: last on the very first bit of a frame
        rate = 2'b01;
        drive(4'd7, 1'b1);
        exp_pair(4'd7, 4'd0, 2'b01, 1'b1, 0);
        finish_frame("T7", 1'b1, 16'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
